ex_stage: RTL

//  Execute stage of the 5-stage MIPS pipeline. Consumes the ID/EX register outputs and produces
//  the GPR write result and the HI/LO write result for the EX/MEM register.

---
 rtl/ex_stage.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
`timescale 1ns/1ps
// ex_stage: execute stage of the 5-stage MIPS pipeline. Logic, shift, arithmetic and 32x32
// multiply resolve in one cycle; DIV/DIVU run a 32-step restoring divider and hold IF..EX via stallreq.
module ex_stage #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int OPW     = 8,
    parameter int SELW    = 3,
    parameter int DIV_CYC = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SELW-1:0] ex_alusel,
    input  logic [OPW-1:0]  ex_aluop,
    input  logic            ex_wreg,
    input  logic [AW-1:0]   ex_waddr,
    input  logic [DW-1:0]   ex_reg1,
    input  logic [DW-1:0]   ex_reg2,
    output logic            wreg_o,
    output logic [AW-1:0]   waddr_o,
    output logic [DW-1:0]   wdata_o,
    output logic            whilo_o,
    output logic [DW-1:0]   hi_o,
    output logic [DW-1:0]   lo_o,
    output logic            stallreq
);

    localparam int SHW = $clog2(DW);
    localparam int CW  = $clog2(DIV_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CYC - 1);

    localparam logic [SELW-1:0] RES_NOP   = SELW'(0);
    localparam logic [SELW-1:0] RES_LOGIC = SELW'(1);
    localparam logic [SELW-1:0] RES_SHIFT = SELW'(2);
    localparam logic [SELW-1:0] RES_ARITH = SELW'(4);
    localparam logic [SELW-1:0] RES_MUL   = SELW'(5);

    localparam logic [OPW-1:0] OP_AND   = 8'b0010_0100;
    localparam logic [OPW-1:0] OP_OR    = 8'b0010_0101;
    localparam logic [OPW-1:0] OP_XOR   = 8'b0010_0110;
    localparam logic [OPW-1:0] OP_NOR   = 8'b0010_0111;
    localparam logic [OPW-1:0] OP_SLL   = 8'b0111_1100;
    localparam logic [OPW-1:0] OP_SRL   = 8'b0000_0010;
    localparam logic [OPW-1:0] OP_SRA   = 8'b0000_0011;
    localparam logic [OPW-1:0] OP_SLT   = 8'b0010_1010;
    localparam logic [OPW-1:0] OP_SLTU  = 8'b0010_1011;
    localparam logic [OPW-1:0] OP_ADD   = 8'b0010_0000;
    localparam logic [OPW-1:0] OP_ADDU  = 8'b0010_0001;
    localparam logic [OPW-1:0] OP_SUB   = 8'b0010_0010;
    localparam logic [OPW-1:0] OP_SUBU  = 8'b0010_0011;
    localparam logic [OPW-1:0] OP_MULT  = 8'b0001_1000;
    localparam logic [OPW-1:0] OP_MULTU = 8'b0001_1001;
    localparam logic [OPW-1:0] OP_DIV   = 8'b0001_1010;
    localparam logic [OPW-1:0] OP_DIVU  = 8'b0001_1011;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DZERO, S_DONE} div_state_t;

    div_state_t      state, state_n;
    logic [DW-1:0]   quo, rem, dvs;
    logic            q_neg, r_neg;
    logic [CW-1:0]   cnt;

    logic            is_div, is_signed_div, is_mul, signed_mul;
    logic            ovf, div_stall;
    logic [SHW-1:0]  sh;
    logic [DW-1:0]   res, sum, diff;
    logic [DW-1:0]   abs1, abs2, div_lo, div_hi;
    logic [2*DW-1:0] mul_a, mul_b, prod;
    logic [DW:0]     shifted, trial;

    // DIV/DIVU are recognised by opcode alone; MULT/MULTU need the MUL result class too.
    assign is_div        = (ex_aluop == OP_DIV) || (ex_aluop == OP_DIVU);
    assign is_signed_div = (ex_aluop == OP_DIV);
    assign is_mul        = (ex_alusel == RES_MUL) &&
                           ((ex_aluop == OP_MULT) || (ex_aluop == OP_MULTU));
    assign signed_mul    = (ex_aluop == OP_MULT);

    assign sh   = ex_reg1[SHW-1:0];
    assign sum  = ex_reg1 + ex_reg2;
    assign diff = ex_reg1 - ex_reg2;

    // Sign-extending to 2*DW makes the truncated unsigned product equal the signed product.
    assign mul_a = {{DW{signed_mul & ex_reg1[DW-1]}}, ex_reg1};
    assign mul_b = {{DW{signed_mul & ex_reg2[DW-1]}}, ex_reg2};
    assign prod  = mul_a * mul_b;

    assign abs1 = (is_signed_div && ex_reg1[DW-1]) ? -ex_reg1 : ex_reg1;
    assign abs2 = (is_signed_div && ex_reg2[DW-1]) ? -ex_reg2 : ex_reg2;

    assign shifted = {rem, quo[DW-1]};
    assign trial   = shifted - {1'b0, dvs};
    assign div_lo  = q_neg ? -quo : quo;
    assign div_hi  = r_neg ? -rem : rem;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (ex_alusel)
            RES_LOGIC: begin
                case (ex_aluop)
                    OP_AND:  res = ex_reg1 & ex_reg2;
                    OP_OR:   res = ex_reg1 | ex_reg2;
                    OP_XOR:  res = ex_reg1 ^ ex_reg2;
                    OP_NOR:  res = ~(ex_reg1 | ex_reg2);
                    default: res = '0;
                endcase
            end
            RES_SHIFT: begin
                case (ex_aluop)
                    OP_SLL:  res = ex_reg2 << sh;
                    OP_SRL:  res = ex_reg2 >> sh;
                    OP_SRA:  res = $signed(ex_reg2) >>> sh;
                    default: res = '0;
                endcase
            end
            RES_ARITH: begin
                case (ex_aluop)
                    OP_ADD: begin
                        res = sum;
                        ovf = (ex_reg1[DW-1] == ex_reg2[DW-1]) && (sum[DW-1] != ex_reg1[DW-1]);
                    end
                    OP_ADDU: res = sum;
                    OP_SUB: begin
                        res = diff;
                        ovf = (ex_reg1[DW-1] != ex_reg2[DW-1]) && (diff[DW-1] != ex_reg1[DW-1]);
                    end
                    OP_SUBU: res = diff;
                    OP_SLT:  res = {{(DW-1){1'b0}}, ($signed(ex_reg1) < $signed(ex_reg2))};
                    OP_SLTU: res = {{(DW-1){1'b0}}, (ex_reg1 < ex_reg2)};
                    default: res = '0;
                endcase
            end
            default: res = '0;
        endcase
    end

    // Divider control: stall is raised in the same cycle the DIV is seen in IDLE.
    always_comb begin
        state_n   = state;
        div_stall = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_div) begin
                    div_stall = 1'b1;
                    state_n   = (ex_reg2 == '0) ? S_DZERO : S_BUSY;
                end
            end
            S_BUSY: begin
                div_stall = 1'b1;
                if (cnt == CNT_LAST) state_n = S_DONE;
            end
            S_DZERO: begin
                div_stall = 1'b1;
                state_n   = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_div) begin
                        // A zero divisor leaves quo/rem at 0 so DONE reports 0/0.
                        quo   <= (ex_reg2 == '0) ? '0 : abs1;
                        rem   <= '0;
                        dvs   <= abs2;
                        q_neg <= is_signed_div & (ex_reg1[DW-1] ^ ex_reg2[DW-1]);
                        r_neg <= is_signed_div & ex_reg1[DW-1];
                        cnt   <= '0;
                    end
                end
                S_BUSY: begin
                    quo <= {quo[DW-2:0], ~trial[DW]};
                    rem <= trial[DW] ? shifted[DW-1:0] : trial[DW-1:0];
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wreg_o   = 1'b0;
        waddr_o  = '0;
        wdata_o  = '0;
        whilo_o  = 1'b0;
        hi_o     = '0;
        lo_o     = '0;
        stallreq = 1'b0;
        if (!rst) begin
            waddr_o  = ex_waddr;
            wdata_o  = res;
            wreg_o   = ex_wreg & ~ovf & ~is_mul & ~is_div;
            stallreq = div_stall;
            if (is_mul) begin
                whilo_o = 1'b1;
                hi_o    = prod[2*DW-1:DW];
                lo_o    = prod[DW-1:0];
            end
            if (state == S_DONE) begin
                whilo_o = 1'b1;
                hi_o    = div_hi;
                lo_o    = div_lo;
            end
        end
    end

endmodule
